// File: rtl/css_mcu0_el2_lsu_trigger_hit.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_lsu_trigger_hit
//
// Takes the LSU M-stage trigger matches and registers them into R. On the
// way it applies chain pairing on (0,1), (2,3), ... and kills the capture on
// a flush. It keeps sticky per-trigger hit status and turns each new R-stage
// hit into a held breakpoint-exception or debug-halt request toward dec. The
// request stays up until dec acknowledges it.
//
// Optional build macro: LSU_TRIG_HIT_CNT_EN adds saturating per-trigger hit
// counters on trig_hit_cnt_o.
//
// Ports:
//   clk_i                  core clock
//   rst_l_i                asynchronous active-low reset
//   lsu_trigger_match_m_i  raw per-trigger match, M stage
//   lsu_flush_m_i          kills the M-stage instruction (no capture)
//   lsu_stall_m_i          blocks M->R advance; R holds
//   trig_chain_i           chain bit per trigger (even indices used)
//   trig_action_i          0 = breakpoint exception, 1 = debug halt
//   mhit_clr_wr_i          CSR write clearing sticky bits
//   mhit_clr_mask_i        sticky bits to clear
//   exc_ack_i / halt_ack_i dec accepted the exception / halt request
//   lsu_trigger_hit_r_o    qualified hits in R
//   lsu_trig_exc_req_o     held breakpoint-exception request
//   lsu_trig_halt_req_o    held debug-halt request
//   trig_mhit_o            sticky hit status
//   lsu_trig_busy_o        a request is pending
//   trig_hit_cnt_o         per-trigger hit counters (LSU_TRIG_HIT_CNT_EN only)
// ---------------------------------------------------------------------------
module css_mcu0_el2_lsu_trigger_hit #(
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                rst_l_i,
  input  logic                clk_i,
  input  logic [NUM_TRIG-1:0] lsu_trigger_match_m_i,
  input  logic                lsu_flush_m_i,
  input  logic                lsu_stall_m_i,
  input  logic [NUM_TRIG-1:0] trig_chain_i,
  input  logic [NUM_TRIG-1:0] trig_action_i,
  input  logic                mhit_clr_wr_i,
  input  logic [NUM_TRIG-1:0] mhit_clr_mask_i,
  input  logic                exc_ack_i,
  input  logic                halt_ack_i,
  output logic [NUM_TRIG-1:0] lsu_trigger_hit_r_o,
  output logic                lsu_trig_exc_req_o,
  output logic                lsu_trig_halt_req_o,
  output logic [NUM_TRIG-1:0] trig_mhit_o,
  output logic                lsu_trig_busy_o
`ifdef LSU_TRIG_HIT_CNT_EN
  ,
  output logic [NUM_TRIG*CNT_W-1:0] trig_hit_cnt_o
`endif
);

  if ((NUM_TRIG % 2) != 0 || NUM_TRIG == 0) begin : g_bad_num_trig
    $error("NUM_TRIG must be a nonzero even number");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  typedef enum logic [1:0] {StIdle, StExcPend, StHaltPend} state_e;

  state_e              state_q, state_d;
  logic [NUM_TRIG-1:0] qual_m;
  logic [NUM_TRIG-1:0] hit_q, hit_d;
  logic                new_q, new_d;
  logic [NUM_TRIG-1:0] mhit_q, mhit_d;
  logic [NUM_TRIG-1:0] clr_vec;
  logic [NUM_TRIG-1:0] evt_hits;
  logic                event_r;

  // Chain pairing: a chained pair fires only when both halves match.
  always_comb begin
    qual_m = lsu_trigger_match_m_i;
    for (int k = 0; k < int'(NUM_TRIG / 2); k++) begin
      if (trig_chain_i[2*k]) begin
        qual_m[2*k]   = lsu_trigger_match_m_i[2*k] & lsu_trigger_match_m_i[2*k+1];
        qual_m[2*k+1] = lsu_trigger_match_m_i[2*k] & lsu_trigger_match_m_i[2*k+1];
      end
    end
  end

  // Odd chain bits carry no meaning here.
  logic unused_chain_odd;
  always_comb begin
    unused_chain_odd = 1'b0;
    for (int k = 0; k < int'(NUM_TRIG / 2); k++) begin
      unused_chain_odd = unused_chain_odd ^ trig_chain_i[2*k+1];
    end
  end

  // R capture; new_q marks the single cycle a fresh nonzero load is visible so
  // a value held through a stall is never acted on twice.
  always_comb begin
    hit_d = hit_q;
    new_d = 1'b0;
    if (!lsu_stall_m_i) begin
      hit_d = qual_m & ~{NUM_TRIG{lsu_flush_m_i}};
      new_d = |hit_d;
    end
  end

  assign event_r  = new_q;
  assign evt_hits = hit_q & {NUM_TRIG{event_r}};
  assign clr_vec  = mhit_clr_mask_i & {NUM_TRIG{mhit_clr_wr_i}};

  // Set wins over clear on the same bit.
  assign mhit_d = (mhit_q & ~clr_vec) | evt_hits;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (event_r) begin
          if (|(hit_q & trig_action_i)) state_d = StHaltPend;
          else                          state_d = StExcPend;
        end
      end
      StExcPend:  if (exc_ack_i)  state_d = StIdle;
      StHaltPend: if (halt_ack_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      state_q <= StIdle;
      hit_q   <= '0;
      new_q   <= 1'b0;
      mhit_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      new_q   <= new_d;
      mhit_q  <= mhit_d;
    end
  end

  assign lsu_trigger_hit_r_o = hit_q;
  assign trig_mhit_o         = mhit_q;
  assign lsu_trig_exc_req_o  = (state_q == StExcPend);
  assign lsu_trig_halt_req_o = (state_q == StHaltPend);
  assign lsu_trig_busy_o     = (state_q != StIdle);

`ifdef LSU_TRIG_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_TRIG];
  logic [CNT_W-1:0] cnt_d [NUM_TRIG];

  // Clear wins over increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < int'(NUM_TRIG); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_vec[i]) begin
        cnt_d[i] = '0;
      end else if (evt_hits[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      for (int i = 0; i < int'(NUM_TRIG); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_TRIG); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < int'(NUM_TRIG); g++) begin : g_cnt_out
    assign trig_hit_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: doc/css_mcu0_el2_lsu_trigger_hit.md
Name: css_mcu0_el2_lsu_trigger_hit

Overview:
Downstream consumer of the LSU M-stage trigger match vector. Registers the four raw matches from M into R, applies chain pairing and flush qualification, and keeps sticky per-trigger hit status. Converts qualified hits into a held breakpoint-exception request or a debug-halt request toward dec, and holds each request until it is acknowledged.

Parameters:
NUM_TRIG, 4, number of triggers; must be even, with chaining applied on pairs (0,1) and (2,3).
CNT_W, 16, width of the per-trigger hit counter (used only with the optional feature).

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
lsu_trigger_match_m  in  NUM_TRIG  raw per-trigger match, M stage
lsu_flush_m  in  1  kills the M-stage instruction; no capture that cycle
lsu_stall_m  in  1  M->R advance blocked; R holds its contents
trig_chain  in  NUM_TRIG  chain bit per trigger; only even indices are used
trig_action  in  NUM_TRIG  0 = breakpoint exception, 1 = debug halt
mhit_clr_wr  in  1  CSR write clearing sticky bits
mhit_clr_mask  in  NUM_TRIG  sticky bits to clear when mhit_clr_wr=1
exc_ack  in  1  dec accepted the exception request
halt_ack  in  1  dec accepted the halt request
lsu_trigger_hit_r  out  NUM_TRIG  qualified hits in R, valid for one advance
lsu_trig_exc_req  out  1  held breakpoint-exception request
lsu_trig_halt_req  out  1  held debug-halt request
trig_mhit  out  NUM_TRIG  sticky hit status
lsu_trig_busy  out  1  a request is pending

Behaviour:
- Reset (rst_l=0, asynchronous): every output and internal register goes to 0; FSM goes to IDLE.
- Chain qualification (combinational on the M inputs), for each pair p=(2k, 2k+1):
  - If trig_chain[2k]=1, both bits of the pair are set only when both raw matches are 1; otherwise both are 0.
  - If trig_chain[2k]=0, each bit passes through unchanged.
- R register:
  - When lsu_stall_m=0, hit_r <= qualified M vector & ~{NUM_TRIG{lsu_flush_m}}.
  - When lsu_stall_m=1, hit_r holds and no new event is generated.
  - lsu_trigger_hit_r = hit_r. Latency is one clock from M to R.
- R event:
  - An event occurs in the cycle hit_r is loaded nonzero, using a one-cycle "new" flag.
  - The same hit_r is never acted on twice during a stall.
- Sticky: trig_mhit[i] <= (trig_mhit[i] & ~(mhit_clr_wr & mhit_clr_mask[i])) | (event & hit_r[i]). If set and clear coincide on the same bit, set wins.
- FSM has three states: IDLE, EXC_PEND, HALT_PEND.
  - IDLE: on an event, if any hit_r[i] has trig_action[i]=1, go to HALT_PEND. Else, if any hit exists, go to EXC_PEND. Halt has priority over exception.
  - EXC_PEND: lsu_trig_exc_req=1. When exc_ack=1, go to IDLE.
  - HALT_PEND: lsu_trig_halt_req=1. When halt_ack=1, go to IDLE.
- Request timing: each request is registered and asserts the cycle after the event. It deasserts the cycle after the ack.
- Acks are ignored when they do not match the current state.
- Events arriving while in EXC_PEND or HALT_PEND update trig_mhit only. They do not change state or start a new request, and there is no queueing.
- lsu_trig_busy = (state != IDLE).
- trig_action is sampled in the cycle the event occurs; later changes do not affect a pending request.
- Mid-operation reset drops any pending request immediately.

Optional Feature:
LSU_TRIG_HIT_CNT_EN
- Defined:
  - Adds output trig_hit_cnt [NUM_TRIG*CNT_W].
  - Each counter increments by 1 on (event & hit_r[i]) and saturates at all-ones.
  - A counter clears to 0 when mhit_clr_wr & mhit_clr_mask[i] is asserted; clear wins over increment.
  - Counters reset to 0.
- Undefined: the port and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Single halt hit: match_m=4'b0001, trig_action=4'b0001, chain=0, no stall -> hit_r=0001 next cycle; halt_req=1 one cycle later and held; halt_ack -> halt_req=0 next cycle; trig_mhit=0001.
- Chain pair: chain[0]=1, match_m=0001 -> hit_r=0000, no request; then match_m=0011 -> hit_r=0011, exc_req=1 (action=0).
- Flush and stall: match_m=0100 with lsu_flush_m=1 -> hit_r=0, trig_mhit=0. Match with stall held for 3 cycles, then released -> exactly one event.
- Priority and pending: match_m=1001 with action[3]=1, action[0]=0 -> HALT_PEND only. A further hit 0010 while pending -> trig_mhit=1011, no exc_req. exc_ack in HALT_PEND is ignored.
- Sticky clear: trig_mhit=1111, mhit_clr_wr=1 with mask=0101 while a hit on trigger 0 occurs the same cycle -> trig_mhit=1011.
- LSU_TRIG_HIT_CNT_EN with CNT_W=2: 5 hits on trigger 1 -> count saturates at 3; a clear with mask=0010 -> count=0.
